// File: rtl/uart_pkg.sv
// +----------------------------------------------------------------------------+
// | uart_pkg : shared types and constants for the MMIO UART transmitter        |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_t;

   localparam logic [31:0] TXDATA_OFF = 32'd0;
   localparam logic [31:0] STATUS_OFF = 32'd4;

   localparam int ST_FULL_BIT   = 0;
   localparam int ST_EMPTY_BIT  = 1;
   localparam int ST_BUSY_BIT   = 2;
   localparam int ST_COUNT_LSB  = 3;
   localparam int ST_COUNT_MSB  = 7;
   localparam int ST_OVF_LSB    = 8;
   localparam int ST_OVF_MSB    = 15;
   localparam int ST_PARITY_BIT = 16;

   // Rounded-to-nearest clocks per serial bit.
   function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
      return (clk_hz + baud / 2) / baud;
   endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_mmio_if.sv
// +----------------------------------------------------------------------------+
// | uart_tx_mmio_if : core store/load port as seen by the UART MMIO block      |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

interface uart_tx_mmio_if;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        mem_write;
   logic [31:0] rdata;

   modport master (output addr, output wdata, output mem_write, input rdata);
   modport slave  (input addr, input wdata, input mem_write, output rdata);
endinterface

`default_nettype wire

// File: rtl/uart_tx_mmio_sync_fifo.sv
// +----------------------------------------------------------------------------+
// | sync_fifo : single-clock FIFO, power-of-two depth, no read bypass          |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Flags come from the pre-edge count, so a same-cycle pop never frees room for a push.
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   assign dout  = mem[rd_ptr];
   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);

endmodule

`default_nettype wire

// File: rtl/uart_tx_mmio.sv
// +----------------------------------------------------------------------------+
// | uart_tx_mmio : memory-mapped 8N1 UART transmitter with TX FIFO and STATUS  |
// | Optional even parity bit when UART_TX_PARITY_EN is defined.                |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module uart_tx_mmio #(
   parameter int unsigned CLK_HZ     = 100000000,
   parameter int unsigned BAUD       = 115200,
   parameter int          FIFO_DEPTH = 16,
   parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0000
) (
   input  logic           clk,
   input  logic           reset,
   uart_tx_mmio_if.slave  bus,
   output logic           tx,
   output logic           tx_busy,
   output logic           irq_empty
);

   import uart_pkg::*;

   localparam int unsigned DIV       = calc_div(CLK_HZ, BAUD);
   localparam int          BW        = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);
`ifdef UART_TX_PARITY_EN
   localparam logic PARITY_PRESENT = 1'b1;
`else
   localparam logic PARITY_PRESENT = 1'b0;
`endif

   tx_state_t     state, state_next;
   logic [BW-1:0] baud_cnt, baud_next;
   logic [7:0]    shift, shift_next;
   logic [2:0]    bit_idx, idx_next;
   logic          par_bit, par_next;
   logic          tx_next;
   logic          bit_done;

   logic          push_sel;
   logic          status_sel;
   logic          fifo_pop;
   logic [7:0]    fifo_dout;
   logic          fifo_full;
   logic          fifo_empty;
   logic [CW-1:0] fifo_count;
   logic [7:0]    ovf_cnt;
   logic [31:0]   count_ext;
   logic [31:0]   status;

   assign push_sel   = bus.mem_write && (bus.addr == BASE_ADDR + TXDATA_OFF);
   assign status_sel = (bus.addr == BASE_ADDR + STATUS_OFF);

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push_sel),
      .din   (bus.wdata[7:0]),
      .pop   (fifo_pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ovf_cnt <= '0;
      end else if (push_sel && fifo_full && (ovf_cnt != 8'hFF)) begin
         ovf_cnt <= ovf_cnt + 8'd1;
      end
   end

   assign bit_done = (baud_cnt == BAUD_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         baud_cnt <= '0;
         shift    <= '0;
         bit_idx  <= '0;
         par_bit  <= 1'b0;
         tx       <= 1'b1;
      end else begin
         state    <= state_next;
         baud_cnt <= baud_next;
         shift    <= shift_next;
         bit_idx  <= idx_next;
         par_bit  <= par_next;
         tx       <= tx_next;
      end
   end

   // tx_next is the line level for the state being entered, so the pin stays a clean flop output.
   always_comb begin
      state_next = state;
      baud_next  = baud_cnt;
      shift_next = shift;
      idx_next   = bit_idx;
      par_next   = par_bit;
      tx_next    = tx;
      fifo_pop   = 1'b0;

      if (state != IDLE) begin
         baud_next = bit_done ? '0 : baud_cnt + BW'(1);
      end

      case (state)
         IDLE: begin
            tx_next = 1'b1;
            if (!fifo_empty) begin
               fifo_pop   = 1'b1;
               shift_next = fifo_dout;
               par_next   = ^fifo_dout;
               baud_next  = '0;
               state_next = START;
               tx_next    = 1'b0;
            end
         end
         START: begin
            if (bit_done) begin
               state_next = DATA;
               idx_next   = 3'd0;
               tx_next    = shift[0];
            end
         end
         DATA: begin
            if (bit_done) begin
               shift_next = shift >> 1;
               idx_next   = bit_idx + 3'd1;
               if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_next = PARITY;
                  tx_next    = par_bit;
`else
                  state_next = STOP;
                  tx_next    = 1'b1;
`endif
               end else begin
                  tx_next = shift[1];
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (bit_done) begin
               state_next = STOP;
               tx_next    = 1'b1;
            end
         end
`endif
         STOP: begin
            if (bit_done) begin
               if (!fifo_empty) begin
                  fifo_pop   = 1'b1;
                  shift_next = fifo_dout;
                  par_next   = ^fifo_dout;
                  state_next = START;
                  tx_next    = 1'b0;
               end else begin
                  state_next = IDLE;
                  tx_next    = 1'b1;
               end
            end
         end
         default: begin
            state_next = IDLE;
            baud_next  = '0;
            tx_next    = 1'b1;
         end
      endcase
   end

   assign tx_busy   = (state != IDLE);
   assign irq_empty = fifo_empty && (state == IDLE);

   assign count_ext = 32'(fifo_count);

   always_comb begin
      status                              = '0;
      status[ST_FULL_BIT]                 = fifo_full;
      status[ST_EMPTY_BIT]                = fifo_empty;
      status[ST_BUSY_BIT]                 = tx_busy;
      status[ST_COUNT_MSB:ST_COUNT_LSB]   = count_ext[4:0];
      status[ST_OVF_MSB:ST_OVF_LSB]       = ovf_cnt;
      status[ST_PARITY_BIT]               = PARITY_PRESENT;
   end

   assign bus.rdata = status_sel ? status : '0;

   wire unused_bits = ^{bus.wdata[31:8], count_ext[31:5], par_bit};

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_mmio.sv
// +----------------------------------------------------------------------------+
// | tb_uart_tx_mmio : directed self-checking bench for uart_tx_mmio            |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_uart_tx_mmio;

   localparam logic [31:0] BASE = 32'hFFFF_0000;
`ifdef UART_TX_PARITY_EN
   localparam int          FB   = 11;
   localparam logic [31:0] PAR  = 32'h0001_0000;
`else
   localparam int          FB   = 10;
   localparam logic [31:0] PAR  = 32'h0000_0000;
`endif

   logic clk   = 1'b0;
   logic reset = 1'b1;
   logic tx;
   logic tx_busy;
   logic irq_empty;
   logic saw_low;
   int   errors = 0;
   int   checks = 0;

   uart_tx_mmio_if bus();

   uart_tx_mmio #(
      .CLK_HZ     (1000),
      .BAUD       (100),
      .FIFO_DEPTH (4),
      .BASE_ADDR  (BASE)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus.slave),
      .tx        (tx),
      .tx_busy   (tx_busy),
      .irq_empty (irq_empty)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One store cycle; returns half a clock after the store edge with STATUS selected.
   task automatic store(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      bus.addr      = a;
      bus.wdata     = d;
      bus.mem_write = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.mem_write = 1'b0;
      bus.addr      = BASE + 32'd4;
      #1;
   endtask

   // Entered at clock start_off (<=5) of a frame; leaves at clock FB*10 of it.
   task automatic check_frame(input logic [7:0] b, input int start_off, input string tag);
      logic [10:0] bits;
      bits = '0;
      for (int i = 0; i < 8; i++) bits[i+1] = b[i];
`ifdef UART_TX_PARITY_EN
      bits[9] = ^b;
`endif
      bits[FB-1] = 1'b1;
      if (start_off == 0) check({tag, "_edge"}, {31'd0, tx}, 32'd0);
      repeat (5 - start_off) @(negedge clk);
      for (int i = 0; i < FB; i++) begin
         check($sformatf("%s_bit%0d", tag, i), {31'd0, tx}, {31'd0, bits[i]});
         if (i < FB - 1) repeat (10) @(negedge clk);
      end
      repeat (4) @(negedge clk);
      check({tag, "_busy_end"}, {31'd0, tx_busy}, 32'd1);
      @(negedge clk);
   endtask

   initial begin
      bus.addr      = BASE + 32'd4;
      bus.wdata     = '0;
      bus.mem_write = 1'b0;
      saw_low       = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // Reset and idle
      repeat (50) @(negedge clk);
      #1;
      check("idle_tx", {31'd0, tx}, 32'd1);
      check("idle_busy", {31'd0, tx_busy}, 32'd0);
      check("idle_irq", {31'd0, irq_empty}, 32'd1);
      check("idle_status", bus.rdata, 32'h0000_0002 | PAR);

      // Single byte 0x55
      store(BASE, 32'h0000_0155);
      check("st1_queued", bus.rdata, 32'h0000_0008 | PAR);
      check("st1_tx_hold", {31'd0, tx}, 32'd1);
      check("st1_irq", {31'd0, irq_empty}, 32'd0);
      @(negedge clk);
      #1;
      check("st1_popped", bus.rdata, 32'h0000_0006 | PAR);
      check("st1_busy", {31'd0, tx_busy}, 32'd1);
      check_frame(8'h55, 0, "f55");
      check("st1_done_busy", {31'd0, tx_busy}, 32'd0);
      check("st1_done_irq", {31'd0, irq_empty}, 32'd1);

      // Burst of five, then one overflow
      @(negedge clk);
      bus.addr      = BASE;
      bus.mem_write = 1'b1;
      for (int i = 0; i < 5; i++) begin
         bus.wdata = 32'h41 + 32'(i);
         @(posedge clk);
         @(negedge clk);
      end
      bus.mem_write = 1'b0;
      bus.addr      = BASE + 32'd4;
      #1;
      check("burst_full", bus.rdata, 32'h0000_0025 | PAR);
      @(negedge clk);
      bus.addr      = BASE;
      bus.wdata     = 32'h46;
      bus.mem_write = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.mem_write = 1'b0;
      bus.addr      = BASE + 32'd4;
      #1;
      check("burst_ovf", bus.rdata, 32'h0000_0125 | PAR);
      check_frame(8'h41, 5, "f41");
      check_frame(8'h42, 0, "f42");
      check_frame(8'h43, 0, "f43");
      check_frame(8'h44, 0, "f44");
      check_frame(8'h45, 0, "f45");
      #1;
      check("burst_idle_busy", {31'd0, tx_busy}, 32'd0);
      check("burst_idle_status", bus.rdata, 32'h0000_0102 | PAR);

      // Store to an unmapped address
      store(BASE + 32'd8, 32'h0000_0077);
      check("other_status", bus.rdata, 32'h0000_0102 | PAR);
      repeat (20) @(negedge clk);
      check("other_tx", {31'd0, tx}, 32'd1);
      check("other_busy", {31'd0, tx_busy}, 32'd0);

      // Reset mid-frame with a byte still queued
      @(negedge clk);
      bus.addr      = BASE;
      bus.wdata     = 32'hA0;
      bus.mem_write = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.wdata     = 32'h5A;
      @(posedge clk);
      @(negedge clk);
      bus.mem_write = 1'b0;
      bus.addr      = BASE + 32'd4;
      #1;
      check("rst_pre_status", bus.rdata, 32'h0000_010C | PAR);
      repeat (35) @(negedge clk);
      check("rst_pre_tx", {31'd0, tx}, 32'd0);
      reset = 1'b1;
      #1;
      check("rst_async_tx", {31'd0, tx}, 32'd1);
      check("rst_busy", {31'd0, tx_busy}, 32'd0);
      check("rst_status", bus.rdata, 32'h0000_0002 | PAR);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (tx !== 1'b1) saw_low = 1'b1;
      end
      check("rst_no_residual", {31'd0, saw_low}, 32'd0);
      check("rst_after_busy", {31'd0, tx_busy}, 32'd0);
      check("rst_after_irq", {31'd0, irq_empty}, 32'd1);

`ifdef UART_TX_PARITY_EN
      store(BASE, 32'h0000_0007);
      check("par_flag", {31'd0, bus.rdata[16]}, 32'd1);
      @(negedge clk);
      check_frame(8'h07, 0, "fpar");
      check("par_done_busy", {31'd0, tx_busy}, 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/uart_tx_mmio.md
Name: uart_tx_mmio

Overview:
- Memory-mapped UART transmitter directly downstream of the single-cycle core's store port.
- Consumes the core's ALU result (store address), store data and memory-write strobe.
- Buffers bytes in a small FIFO and serialises them 8N1 on a TX pin.
- Exposes a combinational status word so software can poll before storing.

Parameters:
- CLK_HZ, 100000000, core clock frequency in Hz.
- BAUD, 115200, serial bit rate.
- FIFO_DEPTH, 16, byte entries; power of two, minimum 2.
- BASE_ADDR, 32'hFFFF_0000, address of the TXDATA register; STATUS is at BASE_ADDR+4.

Ports:
- clk  input  1  core clock.
- reset  input  1  asynchronous, active-high reset.
- addr  input  32  store/load address from the ALU result.
- wdata  input  32  store data; only bits [7:0] are used.
- mem_write  input  1  store strobe from the core.
- rdata  output  32  STATUS word when addr==BASE_ADDR+4, else 0; combinational.
- tx  output  1  serial line; idle high.
- tx_busy  output  1  high while the FSM is not IDLE.
- irq_empty  output  1  high when the FIFO is empty and the FSM is IDLE.

Behaviour:
- Reset (async, active-high):
  - tx=1, tx_busy=0, irq_empty=1.
  - FIFO emptied, overflow counter cleared, FSM to IDLE, baud counter 0.
  - Reset asserted mid-frame aborts the frame immediately; tx goes high asynchronously.
- Divider: DIV = (CLK_HZ + BAUD/2) / BAUD, computed at elaboration. Every serial bit lasts exactly DIV clocks.
- Push:
  - Occurs on a rising edge with mem_write=1 and addr==BASE_ADDR.
  - If the FIFO is not full, wdata[7:0] is written.
  - If full, the byte is dropped and the overflow counter increments, saturating at 255.
  - A pop in the same cycle does not free space for that push (full is evaluated pre-edge).
- Pop: only when count>0. No bypass, so a push into an empty FIFO is popped no earlier than the next edge.
- Stores to any other address are ignored.
- FSM states IDLE, START, DATA, STOP:
  - IDLE: if the FIFO is non-empty, pop into the shift register, go to START, clear the baud counter.
  - START: tx=0 for DIV clocks, then DATA with bit index 0.
  - DATA: tx=shift[0], LSB first. After DIV clocks, shift right and increment the index; after index 7 completes, go to STOP.
  - STOP: tx=1 for DIV clocks. At the end, if the FIFO is non-empty, pop and go to START (back-to-back frames, no gap); else go to IDLE.
- Latency: a store registered at edge N is popped at edge N+1, and tx falls after edge N+1.
- STATUS bits:
  - [0] fifo_full, [1] fifo_empty, [2] tx_busy.
  - [7:3] fifo_count, zero-extended or truncated to 5 bits.
  - [15:8] overflow_cnt, [31:16] zero.
- STATUS reads have no side effects; the overflow counter is cleared only by reset.
- tx is driven from a flop (glitch-free).

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP.
  - tx = XOR of the 8 data bits (even parity) for DIV clocks.
  - Frame is 11 bit-times.
  - STATUS[16] reads 1 to indicate parity is present.
- Undefined: 8N1 as above, 10 bit-times, STATUS[16]=0.

Decomposition:
- Package uart_pkg holds:
  - typedef enum for the FSM states;
  - localparams TXDATA_OFF=0 and STATUS_OFF=4;
  - STATUS bit-position constants;
  - a function computing DIV from CLK_HZ/BAUD.
- One sub-module, sync_fifo:
  - parameterised width/depth; push/pop/full/empty/count;
  - single clock, same async reset.
- uart_tx_mmio holds the address decode, FSM, baud counter and overflow counter.

Test Plan (CLK_HZ=1000, BAUD=100, so DIV=10; FIFO_DEPTH=4; default BASE_ADDR):
- Reset, then idle 50 clocks -> tx=1, tx_busy=0, irq_empty=1, rdata at BASE+4 = 32'h0000_0002.
- Store 32'h0000_0155 to BASE -> tx low 1 clock after the store edge; line shows 0,1,0,1,0,1,0,1,0,1 each 10 clocks; tx_busy=1 for 100 clocks.
- Five consecutive stores 0x41..0x45 while idle:
  - first byte popped immediately, next four queued, none dropped, overflow_cnt=0;
  - a sixth store while the FIFO is still full gives overflow_cnt=1;
  - frames are back-to-back with no idle gap between stop and start.
- Store to BASE+8 with data 0x77 -> no push, tx stays 1, status unchanged.
- Assert reset at clock 35 of a frame -> tx=1 the same cycle, FIFO count 0, FSM IDLE after release, no residual bits.
- With UART_TX_PARITY_EN, store 0x07 -> parity bit 1 after data, frame length 110 clocks, STATUS[16]=1.
